signal_debouncer: RTL and testbench
===================================

Name: signal_debouncer

Overview:
Conditions a raw, asynchronous, possibly bouncing input (button, external strobe, slow GPIO) into a clean, clock-synchronous level. It sits directly upstream of multi_edge_detector: its debounced output drives that block's signal input, so each physical transition produces exactly one edge pulse. Internally it is a synchronizer chain, a stability counter and a 4-state FSM.

Parameters:
STABLE_CYCLES, 16, consecutive synchronized cycles the new level must hold before debounced changes; legal range >= 1.
SYNC_STAGES, 2, flip-flop depth of the input synchronizer; legal range >= 2.
RESET_VALUE, 0, reset level of the synchronizer flops, debounced and the FSM, which resets to the matching STABLE state.

Ports:
clock  input  1  single clock; all flops on rising edge.
resetn  input  1  asynchronous, active-low reset.
signal  input  1  raw asynchronous input; may glitch or bounce.
debounced  output  1  clean synchronous level; registered.
unstable  output  1  high while a candidate transition is being qualified (FSM in CHECK_HIGH or CHECK_LOW); registered.

Behaviour:
- Reset (resetn low, asynchronous, takes effect immediately even mid-qualification):
  - sync chain = RESET_VALUE; debounced = RESET_VALUE; unstable = 0; counter = 0.
  - state = STABLE_HIGH if RESET_VALUE else STABLE_LOW.
- synced = last synchronizer stage. signal is never used outside the synchronizer.
- Counter width is clog2(STABLE_CYCLES+1) and it never wraps.
- In STABLE_LOW / STABLE_HIGH:
  - synced == debounced: stay.
  - mismatch with STABLE_CYCLES == 1: debounced <= synced; stay in the opposite STABLE state.
  - mismatch otherwise: go to CHECK_HIGH / CHECK_LOW; counter <= 1.
- In CHECK_HIGH / CHECK_LOW:
  - synced == debounced (glitch ended): counter <= 0; return to the previous STABLE state; debounced unchanged.
  - mismatch with counter == STABLE_CYCLES-1: debounced <= synced; counter <= 0; go to the new STABLE state.
  - mismatch otherwise: counter <= counter+1.
- Latency: signal set before edge 1 and held flips debounced at edge SYNC_STAGES+STABLE_CYCLES. A shorter pulse never propagates.
- Any bounce restarts qualification from zero. The timing is measured from the last bounce.
- unstable is high after every edge that leaves the FSM in a CHECK state; it is low otherwise.
- debounced changes at most once per qualification window, so downstream edge detection sees one pulse per accepted transition.

Decomposition:
- Shared package: FSM state encoding (STABLE_LOW=2'b00, CHECK_HIGH=2'b01, STABLE_HIGH=2'b11, CHECK_LOW=2'b10) and a clog2 helper function for the counter width.
- One sub-module: synchronizer (SYNC_STAGES deep, RESET_VALUE reset, async active-low reset), instantiated once on signal.
- FSM and counter live in signal_debouncer itself.

Test Plan:
(Defaults for all except item 6: STABLE_CYCLES=4, SYNC_STAGES=2, RESET_VALUE=0.)
1. Reset: resetn low with signal=1 -> debounced=0, unstable=0. Release resetn with signal=0 -> outputs hold 0 indefinitely.
2. Clean step: signal 0->1 before edge 1, held -> unstable=1 after edges 3,4,5; debounced=1 after edge 6 and unstable=0 then. Step back to 0 -> debounced=0 six edges later.
3. Glitch: signal high for 3 cycles, then low -> unstable pulses for 3 cycles; debounced stays 0; a 1-cycle glitch behaves the same way.
4. Bounce: signal toggles 1,0,1,1,0,1 on successive cycles, then held 1 -> exactly one debounced 0->1 transition, occurring 6 edges after the final 0->1 toggle. An attached multi_edge_detector emits exactly one rising_edge pulse.
5. Reset mid-check: resetn asserted while unstable=1 (counter=2) -> debounced=0, unstable=0 immediately. After release with signal still 1, qualification restarts and debounced=1 exactly 6 edges after release.
6. Parameter corner (RESET_VALUE=1, STABLE_CYCLES=1, SYNC_STAGES=3): reset -> debounced=1. signal 1->0 -> debounced=0 at edge 4; unstable never asserts.

Source files
------------

// File: rtl/signal_debouncer_pkg.sv
// Shared types and helpers for the signal debouncer: FSM state encoding and
// the width helper used to size the stability counter.
package signal_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    CHECK_LOW   = 2'b10,
    STABLE_HIGH = 2'b11
  } state_e;

  // Number of bits needed to represent values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/signal_debouncer_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clock domain.
module signal_debouncer_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Debouncer: synchronizer, stability counter and 4-state qualification FSM
// producing a clean registered level plus a "qualifying" indicator.
module signal_debouncer
  import signal_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2,
  parameter bit RESET_VALUE   = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic signal,
  output logic debounced,
  output logic unstable
);

  localparam int              CNT_W       = clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam state_e          RESET_STATE = RESET_VALUE ? STABLE_HIGH : STABLE_LOW;

  state_e           r_state, w_next_state;
  logic [CNT_W-1:0] r_count, w_next_count;
  logic             r_debounced, w_next_debounced;
  logic             r_unstable, w_next_unstable;
  logic             w_synced;
  logic             w_mismatch;

  signal_debouncer_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VALUE(RESET_VALUE)
  ) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .i_async(signal),
    .o_sync (w_synced)
  );

  assign w_mismatch = w_synced ^ r_debounced;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= RESET_STATE;
      r_count     <= '0;
      r_debounced <= RESET_VALUE;
      r_unstable  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      r_debounced <= w_next_debounced;
      r_unstable  <= w_next_unstable;
    end
  end

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      STABLE_LOW, STABLE_HIGH: begin
        if (w_mismatch) begin
          if (STABLE_CYCLES == 1) begin
            w_next_state = (r_state == STABLE_LOW) ? STABLE_HIGH : STABLE_LOW;
          end else begin
            w_next_state = (r_state == STABLE_LOW) ? CHECK_HIGH : CHECK_LOW;
          end
        end
      end
      CHECK_HIGH: begin
        if (!w_mismatch)              w_next_state = STABLE_LOW;
        else if (r_count == CNT_LAST) w_next_state = STABLE_HIGH;
      end
      CHECK_LOW: begin
        if (!w_mismatch)              w_next_state = STABLE_HIGH;
        else if (r_count == CNT_LAST) w_next_state = STABLE_LOW;
      end
      default: w_next_state = RESET_STATE;
    endcase
  end

  always_comb begin
    w_next_count     = r_count;
    w_next_debounced = r_debounced;
    case (r_state)
      STABLE_LOW, STABLE_HIGH: begin
        if (w_mismatch) begin
          if (STABLE_CYCLES == 1) w_next_debounced = w_synced;
          else                    w_next_count     = CNT_W'(1);
        end
      end
      CHECK_HIGH, CHECK_LOW: begin
        if (!w_mismatch) begin
          w_next_count = '0;
        end else if (r_count == CNT_LAST) begin
          w_next_debounced = w_synced;
          w_next_count     = '0;
        end else begin
          w_next_count = r_count + CNT_W'(1);
        end
      end
      default: w_next_count = '0;
    endcase
    // Any bounce lands back in a STABLE state, so the count restarts from zero.
    w_next_unstable = (w_next_state == CHECK_HIGH) || (w_next_state == CHECK_LOW);
  end

  assign debounced = r_debounced;
  assign unstable  = r_unstable;

endmodule

// File: tb/tb_signal_debouncer.sv
// Directed testbench for signal_debouncer: default instance plus a corner
// instance with RESET_VALUE=1, STABLE_CYCLES=1, SYNC_STAGES=3.
module tb_signal_debouncer;

  logic clock = 1'b0;
  logic resetn, signal, debounced, unstable;
  logic resetn_c, signal_c, debounced_c, unstable_c;

  int tests_run    = 0;
  int tests_failed = 0;
  int rise_count   = 0;
  logic prev_deb   = 1'b0;

  always #5 clock = ~clock;

  signal_debouncer #(
    .STABLE_CYCLES(4),
    .SYNC_STAGES  (2),
    .RESET_VALUE  (1'b0)
  ) u_dut (
    .clock    (clock),
    .resetn   (resetn),
    .signal   (signal),
    .debounced(debounced),
    .unstable (unstable)
  );

  signal_debouncer #(
    .STABLE_CYCLES(1),
    .SYNC_STAGES  (3),
    .RESET_VALUE  (1'b1)
  ) u_dut_c (
    .clock    (clock),
    .resetn   (resetn_c),
    .signal   (signal_c),
    .debounced(debounced_c),
    .unstable (unstable_c)
  );

  // Stand-in for a downstream edge detector: counts debounced 0->1 transitions.
  always @(posedge clock) begin
    if (debounced === 1'b1 && prev_deb === 1'b0) rise_count <= rise_count + 1;
    prev_deb <= debounced;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    signal = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (debounced !== 1'b0 || unstable !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_assert: debounced=%b unstable=%b expected 0/0", debounced, unstable);
    end
    signal = 1'b0;
    resetn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests_run++;
      if (debounced !== 1'b0 || unstable !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold edge %0d: debounced=%b unstable=%b expected 0/0",
                 k, debounced, unstable);
      end
    end
  endtask

  task automatic test_clean_step();
    logic exp_deb, exp_unst;
    signal = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_deb  = (k >= 6);
      exp_unst = (k >= 3 && k <= 5);
      tests_run++;
      if (debounced !== exp_deb || unstable !== exp_unst) begin
        tests_failed++;
        $display("FAIL step_rise edge %0d: debounced=%b unstable=%b expected %b/%b",
                 k, debounced, unstable, exp_deb, exp_unst);
      end
    end
    signal = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_deb  = (k < 6);
      exp_unst = (k >= 3 && k <= 5);
      tests_run++;
      if (debounced !== exp_deb || unstable !== exp_unst) begin
        tests_failed++;
        $display("FAIL step_fall edge %0d: debounced=%b unstable=%b expected %b/%b",
                 k, debounced, unstable, exp_deb, exp_unst);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_unst;
    signal = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) signal = 1'b0;
      exp_unst = (k >= 3 && k <= 5);
      tests_run++;
      if (debounced !== 1'b0 || unstable !== exp_unst) begin
        tests_failed++;
        $display("FAIL glitch3 edge %0d: debounced=%b unstable=%b expected 0/%b",
                 k, debounced, unstable, exp_unst);
      end
    end
    signal = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) signal = 1'b0;
      exp_unst = (k == 3);
      tests_run++;
      if (debounced !== 1'b0 || unstable !== exp_unst) begin
        tests_failed++;
        $display("FAIL glitch1 edge %0d: debounced=%b unstable=%b expected 0/%b",
                 k, debounced, unstable, exp_unst);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_deb;
    int   rc0;
    rc0 = rise_count;
    for (int i = 0; i < 6; i++) begin
      signal = pat[i];
      tick();
      tests_run++;
      if (debounced !== 1'b0) begin
        tests_failed++;
        $display("FAIL bounce_toggle edge %0d: debounced=%b expected 0", i + 1, debounced);
      end
    end
    // Final 0->1 toggle was sampled at edge 6; debounced must rise at edge 11.
    for (int k = 7; k <= 14; k++) begin
      tick();
      exp_deb = (k >= 11);
      tests_run++;
      if (debounced !== exp_deb) begin
        tests_failed++;
        $display("FAIL bounce_settle edge %0d: debounced=%b expected %b", k, debounced, exp_deb);
      end
    end
    repeat (2) tick();
    tests_run++;
    if (rise_count - rc0 !== 1) begin
      tests_failed++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rise_count - rc0);
    end
    signal = 1'b0;
    repeat (8) tick();
    tests_run++;
    if (debounced !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_return: debounced=%b expected 0", debounced);
    end
  endtask

  task automatic test_reset_mid_check();
    logic exp_deb, exp_unst;
    signal = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (unstable !== 1'b1 || debounced !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_pre: debounced=%b unstable=%b expected 0/1", debounced, unstable);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (debounced !== 1'b0 || unstable !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: debounced=%b unstable=%b expected 0/0", debounced, unstable);
    end
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_deb  = (k >= 6);
      exp_unst = (k >= 3 && k <= 5);
      tests_run++;
      if (debounced !== exp_deb || unstable !== exp_unst) begin
        tests_failed++;
        $display("FAIL midreset_requal edge %0d: debounced=%b unstable=%b expected %b/%b",
                 k, debounced, unstable, exp_deb, exp_unst);
      end
    end
  endtask

  task automatic test_corner();
    logic exp_deb;
    resetn_c = 1'b0;
    signal_c = 1'b1;
    tick();
    tests_run++;
    if (debounced_c !== 1'b1 || unstable_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_reset: debounced=%b unstable=%b expected 1/0", debounced_c, unstable_c);
    end
    resetn_c = 1'b1;
    repeat (3) tick();
    signal_c = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_deb = (k < 4);
      tests_run++;
      if (debounced_c !== exp_deb || unstable_c !== 1'b0) begin
        tests_failed++;
        $display("FAIL corner_fall edge %0d: debounced=%b unstable=%b expected %b/0",
                 k, debounced_c, unstable_c, exp_deb);
      end
    end
    signal_c = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_deb = (k >= 4);
      tests_run++;
      if (debounced_c !== exp_deb || unstable_c !== 1'b0) begin
        tests_failed++;
        $display("FAIL corner_rise edge %0d: debounced=%b unstable=%b expected %b/0",
                 k, debounced_c, unstable_c, exp_deb);
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    signal   = 1'b1;
    resetn_c = 1'b0;
    signal_c = 1'b1;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_reset_mid_check();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
